// File: rtl/stim_sequencer.sv
// Stimulus-run sequencer: gates operand issue per vector and emits one check
// strobe per vector after the latched DUT latency. Optional feature: STIM_SEQ_ERROR_STOP_EN.
module stim_sequencer #(
  parameter int CNT_W   = 16,
  parameter int LAT_MAX = 8,
  parameter int LAT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pause,
  input  logic [CNT_W-1:0] i_num_vectors,
  input  logic [LAT_W-1:0] i_dut_latency,
  input  logic             i_mismatch,
  output logic             o_issue,
  output logic             o_check,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_issued_cnt,
  output logic [CNT_W-1:0] o_checked_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   checked_q, checked_d;
  logic               issue_q, issue_d;
  logic               check_q, check_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [LAT_MAX-1:0] dline_q, dline_d;
  logic               tap;

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] l);
    if (l == '0)                 return LAT_W'(1);
    else if (l > LAT_W'(LAT_MAX)) return LAT_W'(LAT_MAX);
    else                          return l;
  endfunction

`ifndef STIM_SEQ_ERROR_STOP_EN
  logic unused_mismatch;
  assign unused_mismatch = i_mismatch;
`endif

  // NOTE: combinational next-state logic uses blocking assignments, and every
  // _d signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    lat_d     = lat_q;
    issued_d  = issued_q;
    checked_d = checked_q;
    error_d   = error_q;
    issue_d   = 1'b0;
    check_d   = 1'b0;
    dline_d   = '0;

    tap = 1'b0;
    for (int k = 0; k < LAT_MAX; k++) begin
      if (lat_q == LAT_W'(k + 1)) tap = dline_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d       = i_num_vectors;
          lat_d     = clamp_lat(i_dut_latency);
          issued_d  = '0;
          checked_d = '0;
          error_d   = 1'b0;
          state_d   = (i_num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!i_pause) begin
          issue_d  = 1'b1;
          issued_d = issued_q + CNT_W'(1);
          if (issued_q + CNT_W'(1) == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (checked_q == n_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // The delay line only carries issue pulses while a run is active; leaving
    // RUN/DRAIN flushes it so a following run never sees stale pulses.
    if (state_q == S_RUN || state_q == S_DRAIN) begin
      check_d = tap;
      dline_d = {dline_q[LAT_MAX-2:0], issue_d};
      if (tap) checked_d = checked_q + CNT_W'(1);
    end

`ifdef STIM_SEQ_ERROR_STOP_EN
    if ((state_q == S_RUN || state_q == S_DRAIN) && i_mismatch) begin
      error_d   = 1'b1;
      state_d   = S_DONE;
      issue_d   = 1'b0;
      check_d   = 1'b0;
      issued_d  = issued_q;
      checked_d = checked_q;
      dline_d   = '0;
    end
`endif

    // Abort wins over everything; counters keep their values for readback.
    if (i_abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      issue_d   = 1'b0;
      check_d   = 1'b0;
      issued_d  = issued_q;
      checked_d = checked_q;
      error_d   = error_q;
      dline_d   = '0;
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      lat_q     <= LAT_W'(1);
      issued_q  <= '0;
      checked_q <= '0;
      issue_q   <= 1'b0;
      check_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      dline_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      lat_q     <= lat_d;
      issued_q  <= issued_d;
      checked_q <= checked_d;
      issue_q   <= issue_d;
      check_q   <= check_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      dline_q   <= dline_d;
    end
  end

  assign o_issue       = issue_q;
  assign o_check       = check_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_issued_cnt  = issued_q;
  assign o_checked_cnt = checked_q;
  assign o_state       = state_q;

endmodule
